// File: rtl/cksum_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : cksum_engine_if
//  Description : Byte-addressed memory port used by the checksum engine.
//                The engine is the master and issues accesses. The memory is
//                the slave and completes them with mem_ready_i.
//  Revision    : 1.0  initial release
// ============================================================================
interface cksum_engine_if #(
    parameter int ADDR_W = 32
);
    logic              mem_ce_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [3:0]        mem_width_o;
    logic [31:0]       mem_data_o;
    logic [31:0]       mem_data_i;
    logic              mem_ready_i;

    modport master (
        output mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o,
        input  mem_data_i, mem_ready_i
    );

    modport slave (
        input  mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o,
        output mem_data_i, mem_ready_i
    );
endinterface
`default_nettype wire

// File: rtl/cksum_engine.sv
`default_nettype none
// ============================================================================
//  Module      : cksum_engine
//  Description : Internet (ones'-complement) checksum engine. The engine reads
//                a byte field from memory and accumulates it as 16-bit words,
//                then folds the sum. In GENERATE mode it stores the
//                complemented sum. In VERIFY mode it checks that the folded
//                sum is 16'hFFFF.
//  Revision    : 1.0  initial release
// ============================================================================
module cksum_engine #(
    parameter int ADDR_W     = 32,
    parameter int BEAT_BYTES = 4,
    parameter int ACC_W      = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start_i,
    input  wire logic              mode_i,
    input  wire logic [ADDR_W-1:0] field_start_i,
    input  wire logic [15:0]       field_len_i,
    input  wire logic [ADDR_W-1:0] dst_field_start_i,
    input  wire logic [15:0]       seed_i,
    cksum_engine_if.master         mem,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   ok_o,
    output logic [15:0]            cksum_o
);

    // The first fold must be at least 17 bits wide so that the second fold
    // can always take a carry slice above bit 15.
    localparam int c_FOLD_W = ((ACC_W - 15) > 17) ? (ACC_W - 15) : 17;
    localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ADDR_W'(BEAT_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_READ  = 3'd2,
        ST_FOLD  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_mode;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_dst;
    logic [15:0]       r_remaining;
    logic [ACC_W-1:0]  r_acc;
    logic [15:0]       r_cksum;
    logic              r_ok;

    logic [3:0]        w_width;
    logic [16:0]       w_beat_sum;
    logic [c_FOLD_W-1:0] w_fold1;
    logic [16:0]       w_fold2;
    logic [15:0]       w_sum16;

    // Choose the read width: a full beat only when it is aligned and fits.
    always_comb begin
        if ((r_remaining >= 16'(BEAT_BYTES)) && ((r_addr & c_ALIGN_MASK) == '0))
            w_width = 4'(BEAT_BYTES);
        else if (r_remaining >= 16'd2)
            w_width = 4'd2;
        else
            w_width = 4'd1;
    end

    // Convert the returned read data into 16-bit word contributions.
    // A lone trailing byte is the high half of a zero-padded word.
    always_comb begin
        case (w_width)
            4'd4:    w_beat_sum = 17'(mem.mem_data_i[31:16]) + 17'(mem.mem_data_i[15:0]);
            4'd2:    w_beat_sum = 17'(mem.mem_data_i[15:0]);
            default: w_beat_sum = {1'b0, mem.mem_data_i[7:0], 8'h00};
        endcase
    end

    // Fold the accumulator to 16 bits with two end-around-carry folds.
    always_comb begin
        w_fold1 = c_FOLD_W'(r_acc[15:0]) + c_FOLD_W'(r_acc[ACC_W-1:16]);
        w_fold2 = 17'(w_fold1[15:0]) + 17'(w_fold1[c_FOLD_W-1:16]);
        w_sum16 = w_fold2[15:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Compute the next state. Unknown encodings fall back to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start_i) w_next = mode_i ? ST_READ : ST_CLEAR;
            ST_CLEAR: if (mem.mem_ready_i) w_next = ST_READ;
            ST_READ:  if (r_remaining == 16'd0) w_next = ST_FOLD;
            ST_FOLD:  w_next = r_mode ? ST_DONE : ST_WRITE;
            ST_WRITE: if (mem.mem_ready_i) w_next = ST_DONE;
            ST_DONE:  if (!start_i) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Latch the job on start, accumulate read beats, and fold the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode      <= 1'b0;
            r_addr      <= '0;
            r_dst       <= '0;
            r_remaining <= '0;
            r_acc       <= '0;
            r_cksum     <= '0;
            r_ok        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_mode      <= mode_i;
                        r_addr      <= field_start_i;
                        r_dst       <= dst_field_start_i;
                        r_remaining <= field_len_i;
                        r_acc       <= ACC_W'(seed_i);
                        r_cksum     <= '0;
                        r_ok        <= 1'b0;
                    end
                end
                ST_READ: begin
                    if ((r_remaining != 16'd0) && mem.mem_ready_i) begin
                        r_acc       <= r_acc + ACC_W'(w_beat_sum);
                        r_addr      <= r_addr + ADDR_W'(w_width);
                        r_remaining <= r_remaining - 16'(w_width);
                    end
                end
                ST_FOLD: begin
                    r_cksum <= ~w_sum16;
                    r_ok    <= r_mode ? (w_sum16 == 16'hFFFF) : 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Drive the memory port. The port is driven only from registered state,
    // so the request holds steady while the memory stalls.
    always_comb begin
        mem.mem_ce_o    = 1'b0;
        mem.mem_we_o    = 1'b0;
        mem.mem_addr_o  = '0;
        mem.mem_width_o = 4'd0;
        mem.mem_data_o  = 32'd0;
        case (r_state)
            ST_CLEAR: begin
                mem.mem_ce_o    = 1'b1;
                mem.mem_we_o    = 1'b1;
                mem.mem_addr_o  = r_dst;
                mem.mem_width_o = 4'd2;
            end
            ST_READ: begin
                if (r_remaining != 16'd0) begin
                    mem.mem_ce_o    = 1'b1;
                    mem.mem_addr_o  = r_addr;
                    mem.mem_width_o = w_width;
                end
            end
            ST_WRITE: begin
                mem.mem_ce_o    = 1'b1;
                mem.mem_we_o    = 1'b1;
                mem.mem_addr_o  = r_dst;
                mem.mem_width_o = 4'd2;
                mem.mem_data_o  = {16'h0000, r_cksum};
            end
            default: ;
        endcase
    end

    // Status outputs.
    always_comb begin
        busy_o  = (r_state != ST_IDLE) && (r_state != ST_DONE);
        done_o  = (r_state == ST_DONE);
        ok_o    = r_ok;
        cksum_o = r_cksum;
    end

endmodule
`default_nettype wire

// File: tb/tb_cksum_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cksum_engine
//  Description : Scoreboard bench for cksum_engine. Each directed job pushes
//                the memory accesses and the completion it expects. A monitor
//                pops one entry for every access or completion the DUT
//                produces and compares it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cksum_engine;

    localparam logic [1:0] c_K_READ  = 2'd0;
    localparam logic [1:0] c_K_WRITE = 2'd1;
    localparam logic [1:0] c_K_DONE  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [3:0]  width;
        logic [15:0] data;
        logic        ok;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        mode_i = 1'b0;
    logic [31:0] field_start_i = '0;
    logic [15:0] field_len_i = '0;
    logic [31:0] dst_field_start_i = '0;
    logic [15:0] seed_i = '0;
    logic        busy_o, done_o, ok_o;
    logic [15:0] cksum_o;

    logic        stall_en = 1'b0;
    logic        hold_low = 1'b0;
    logic [7:0]  m [0:255];
    ev_t         exp_q [$];
    int          errors = 0;
    int          checks = 0;

    cksum_engine_if #(.ADDR_W(32)) mem_bus ();

    cksum_engine #(.ADDR_W(32), .BEAT_BYTES(4), .ACC_W(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .start_i           (start_i),
        .mode_i            (mode_i),
        .field_start_i     (field_start_i),
        .field_len_i       (field_len_i),
        .dst_field_start_i (dst_field_start_i),
        .seed_i            (seed_i),
        .mem               (mem_bus.master),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .ok_o              (ok_o),
        .cksum_o           (cksum_o)
    );

    always #5 clk = ~clk;

    // Memory model: right-aligned read data, first byte most significant.
    always_comb begin
        logic [7:0] a;
        a = mem_bus.mem_addr_o[7:0];
        case (mem_bus.mem_width_o)
            4'd4:    mem_bus.mem_data_i = {m[a], m[8'(a + 8'd1)], m[8'(a + 8'd2)], m[8'(a + 8'd3)]};
            4'd2:    mem_bus.mem_data_i = {16'h0000, m[a], m[8'(a + 8'd1)]};
            default: mem_bus.mem_data_i = {24'h000000, m[a]};
        endcase
    end

    always @(posedge clk) begin
        if (mem_bus.mem_ce_o && mem_bus.mem_we_o && mem_bus.mem_ready_i) begin
            m[mem_bus.mem_addr_o[7:0]]              = mem_bus.mem_data_o[15:8];
            m[8'(mem_bus.mem_addr_o[7:0] + 8'd1)]   = mem_bus.mem_data_o[7:0];
        end
    end

    initial mem_bus.mem_ready_i = 1'b1;
    always @(posedge clk) begin
        #1;
        if (hold_low)
            mem_bus.mem_ready_i = 1'b0;
        else if (stall_en)
            mem_bus.mem_ready_i = ($urandom_range(0, 2) != 0);
        else
            mem_bus.mem_ready_i = 1'b1;
    end

    task automatic check_event(input ev_t act);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: got %h but expected nothing", act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL event: got %h expected %h", act, e);
            end
        end
    endtask

    // Monitor: compares completed accesses, completions and stall stability.
    logic        prev_stall = 1'b0;
    logic        prev_rst   = 1'b1;
    logic        prev_done  = 1'b0;
    logic [72:0] prev_req   = '0;
    always @(negedge clk) begin
        ev_t         act;
        logic [72:0] req;
        req = {mem_bus.mem_ce_o, mem_bus.mem_we_o, mem_bus.mem_addr_o,
               mem_bus.mem_width_o, mem_bus.mem_data_o};
        if (prev_stall && !prev_rst) begin
            checks++;
            if (req !== prev_req) begin
                errors++;
                $display("FAIL stall_stable: got %h expected %h", req, prev_req);
            end
        end
        if (!rst && mem_bus.mem_ce_o && mem_bus.mem_ready_i) begin
            act.kind  = mem_bus.mem_we_o ? c_K_WRITE : c_K_READ;
            act.addr  = mem_bus.mem_addr_o;
            act.width = mem_bus.mem_width_o;
            act.data  = mem_bus.mem_we_o ? mem_bus.mem_data_o[15:0] : 16'h0000;
            act.ok    = 1'b0;
            check_event(act);
        end
        if (!rst && done_o && !prev_done) begin
            act.kind  = c_K_DONE;
            act.addr  = '0;
            act.width = 4'd0;
            act.data  = cksum_o;
            act.ok    = ok_o;
            check_event(act);
        end
        prev_stall = mem_bus.mem_ce_o && !mem_bus.mem_ready_i;
        prev_req   = req;
        prev_rst   = rst;
        prev_done  = done_o;
    end

    task automatic push(input logic [1:0] k, input logic [31:0] a, input logic [3:0] w,
                        input logic [15:0] d, input logic ok);
        ev_t e;
        e.kind = k; e.addr = a; e.width = w; e.data = d; e.ok = ok;
        exp_q.push_back(e);
    endtask

    task automatic push_ipv4_reads();
        for (int i = 0; i < 5; i++) push(c_K_READ, 32'h40 + 32'(4 * i), 4'd4, 16'h0, 1'b0);
    endtask

    task automatic check_idle_outputs(input string name);
        logic [88:0] v;
        v = {mem_bus.mem_ce_o, mem_bus.mem_we_o, mem_bus.mem_addr_o, mem_bus.mem_width_o,
             mem_bus.mem_data_o, busy_o, done_o, ok_o, cksum_o};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL %s: got %h expected 0", name, v);
        end
    endtask

    task automatic run_job(input logic md, input logic [31:0] fs, input logic [15:0] len,
                           input logic [31:0] dst, input logic [15:0] seed);
        int n;
        @(posedge clk); #2;
        mode_i = md; field_start_i = fs; field_len_i = len;
        dst_field_start_i = dst; seed_i = seed; start_i = 1'b1;
        n = 0;
        while (!done_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done_o) begin
            errors++;
            $display("FAIL done_timeout: got done_o=%0b expected 1", done_o);
        end
        @(posedge clk); #2;
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained: got %0d pending expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) m[i] = 8'h00;
        begin
            logic [7:0] hdr [0:19];
            hdr = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                    8'hAB, 8'hCD, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
            for (int i = 0; i < 20; i++) m[8'h40 + i] = hdr[i];
        end
        m[8'h80] = 8'h01; m[8'h81] = 8'h02; m[8'h82] = 8'h03; m[8'h83] = 8'hFF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset_state");
        @(posedge clk); #2;
        rst = 1'b0;

        // GENERATE over the IPv4 header: clear, five beats, store B861.
        push(c_K_WRITE, 32'h4A, 4'd2, 16'h0000, 1'b0);
        push_ipv4_reads();
        push(c_K_WRITE, 32'h4A, 4'd2, 16'hB861, 1'b0);
        push(c_K_DONE, 32'h0, 4'd0, 16'hB861, 1'b1);
        run_job(1'b0, 32'h40, 16'd20, 32'h4A, 16'h0000);

        // VERIFY the stored header: folded sum FFFF, no writes.
        push_ipv4_reads();
        push(c_K_DONE, 32'h0, 4'd0, 16'h0000, 1'b1);
        run_job(1'b1, 32'h40, 16'd20, 32'h4A, 16'h0000);

        // VERIFY with one byte corrupted: folded sum FFFE.
        m[8'h53] = 8'hC6;
        push_ipv4_reads();
        push(c_K_DONE, 32'h0, 4'd0, 16'h0001, 1'b0);
        run_job(1'b1, 32'h40, 16'd20, 32'h4A, 16'h0000);
        m[8'h53] = 8'hC7;

        // Odd length: a 2-byte beat then a padded 1-byte beat.
        push(c_K_WRITE, 32'h90, 4'd2, 16'h0000, 1'b0);
        push(c_K_READ, 32'h80, 4'd2, 16'h0, 1'b0);
        push(c_K_READ, 32'h82, 4'd1, 16'h0, 1'b0);
        push(c_K_WRITE, 32'h90, 4'd2, 16'hFBFD, 1'b0);
        push(c_K_DONE, 32'h0, 4'd0, 16'hFBFD, 1'b1);
        run_job(1'b0, 32'h80, 16'd3, 32'h90, 16'h0000);

        // Zero length with a seed: no reads.
        push(c_K_WRITE, 32'h94, 4'd2, 16'h0000, 1'b0);
        push(c_K_WRITE, 32'h94, 4'd2, 16'hEDCB, 1'b0);
        push(c_K_DONE, 32'h0, 4'd0, 16'hEDCB, 1'b1);
        run_job(1'b0, 32'h80, 16'd0, 32'h94, 16'h1234);

        // GENERATE again under random ready stalls.
        stall_en = 1'b1;
        push(c_K_WRITE, 32'h4A, 4'd2, 16'h0000, 1'b0);
        push_ipv4_reads();
        push(c_K_WRITE, 32'h4A, 4'd2, 16'hB861, 1'b0);
        push(c_K_DONE, 32'h0, 4'd0, 16'hB861, 1'b1);
        run_job(1'b0, 32'h40, 16'd20, 32'h4A, 16'h0000);
        stall_en = 1'b0;

        // Reset while a read is pending, then rerun the job cleanly.
        push(c_K_WRITE, 32'h4A, 4'd2, 16'h0000, 1'b0);
        push_ipv4_reads();
        @(posedge clk); #2;
        mode_i = 1'b0; field_start_i = 32'h40; field_len_i = 16'd20;
        dst_field_start_i = 32'h4A; seed_i = 16'h0000; start_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_bus.mem_ce_o && !mem_bus.mem_we_o) && n < 200);
        checks++;
        if (!(mem_bus.mem_ce_o && !mem_bus.mem_we_o)) begin
            errors++;
            $display("FAIL read_seen: got ce=%0b we=%0b expected a read", mem_bus.mem_ce_o, mem_bus.mem_we_o);
        end
        hold_low = 1'b1;
        @(posedge clk); #2;
        rst = 1'b1;
        start_i = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset_mid_read");
        @(posedge clk); #2;
        rst = 1'b0;
        hold_low = 1'b0;
        repeat (4) @(negedge clk);
        check_idle_outputs("idle_after_reset");

        push(c_K_WRITE, 32'h4A, 4'd2, 16'h0000, 1'b0);
        push_ipv4_reads();
        push(c_K_WRITE, 32'h4A, 4'd2, 16'hB861, 1'b0);
        push(c_K_DONE, 32'h0, 4'd0, 16'hB861, 1'b1);
        run_job(1'b0, 32'h40, 16'd20, 32'h4A, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
